// File: rtl/mem_rr_sched_pkg.sv
// Shared types and width helpers for the round-robin memory scheduler.
package mem_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Width of a client index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the wait-state counter; never narrower than one bit.
    function automatic int cnt_w(input int wait_states);
        return (wait_states > 0) ? $clog2(wait_states + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_sched_if.sv
// Client-side request/ready bundle; master = CPU stages, slave = scheduler.
interface mem_rr_sched_if #(
    parameter int CLIENT_CNT = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
);
    logic [CLIENT_CNT-1:0]        requests;
    logic [CLIENT_CNT*ADDR_W-1:0] addrs;
    logic [CLIENT_CNT-1:0]        wes;
    logic [CLIENT_CNT*DATA_W-1:0] data_outs;
    logic [CLIENT_CNT-1:0]        locks;
    logic [CLIENT_CNT-1:0]        readies;
    logic [DATA_W-1:0]            rdata;

    modport master (
        output requests, addrs, wes, data_outs, locks,
        input  readies, rdata
    );

    modport slave (
        input  requests, addrs, wes, data_outs, locks,
        output readies, rdata
    );
endinterface

// File: rtl/mem_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick
    import mem_rr_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] ptr,
    output logic                valid,
    output logic [idx_w(N)-1:0] idx
);
    localparam int IW = idx_w(N);

    always_comb begin
        // NOTE: every output gets a default before the search so no path infers a latch.
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_rr_sched.sv
// Round-robin scheduler sharing one single-port memory among CPU stages,
// with programmable wait states and a bus lock for atomic read-modify-write.
module mem_rr_sched
    import mem_rr_sched_pkg::*;
#(
    parameter int CLIENT_CNT  = 2,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    mem_rr_sched_if.slave                 bus,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [ADDR_W-1:0]             addr,
    output logic [DATA_W-1:0]             data_out,
    output logic                          we,
    output logic [$clog2(CLIENT_CNT)-1:0] grant_id,
    output logic                          busy
);
    localparam int GID_W = idx_w(CLIENT_CNT);
    localparam int CNT_W = cnt_w(WAIT_STATES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GID_W-1:0]      ptr_q, ptr_d;
    logic [GID_W-1:0]      gid_q, gid_d;
    logic [CLIENT_CNT-1:0] readies_q, readies_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  we_q, we_d;

    logic                  pick_valid;
    logic [GID_W-1:0]      pick_idx;
    logic                  start;
    logic [GID_W-1:0]      start_idx;

    rr_pick #(.N(CLIENT_CNT)) u_pick (
        .req   (bus.requests),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        readies_d = readies_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        we_d      = we_q;
        start     = 1'b0;
        start_idx = pick_idx;

        case (state_q)
            ST_IDLE: begin
                we_d = 1'b0;
                if (pick_valid) begin
                    start = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    readies_d        = '0;
                    readies_d[gid_q] = 1'b1;
                    we_d             = 1'b0;
                    if (!bus.wes[gid_q]) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // The pointer only advances once the owner has seen its ready.
                if (!bus.requests[gid_q]) begin
                    readies_d = '0;
                    ptr_d     = gid_q;
                    state_d   = bus.locks[gid_q] ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Locked owner keeps the bus; other requesters are ignored here.
                start_idx = gid_q;
                if (bus.requests[gid_q]) begin
                    start = 1'b1;
                end else if (!bus.locks[gid_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            gid_d   = start_idx;
            addr_d  = bus.addrs[start_idx*ADDR_W +: ADDR_W];
            dout_d  = bus.data_outs[start_idx*DATA_W +: DATA_W];
            we_d    = bus.wes[start_idx];
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = ST_ACCESS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= GID_W'(CLIENT_CNT - 1);
            gid_q     <= '0;
            readies_q <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            readies_q <= readies_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
        end
    end

    assign bus.readies = readies_q;
    assign bus.rdata   = rdata_q;
    assign addr        = addr_q;
    assign data_out    = dout_q;
    assign we          = we_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_rr_sched.sv
// Randomized bench for mem_rr_sched: per-round job lists checked against a
// transaction-level model of service order, timing and memory contents.
module tb_mem_rr_sched;
    localparam int NC = 2;
    localparam int WS = 1;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;
        bit            l;
    } job_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DW-1:0]         mem_rdata;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         data_out;
    logic                  we;
    logic [$clog2(NC)-1:0] grant_id;
    logic                  busy;

    mem_rr_sched_if #(.CLIENT_CNT(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_rr_sched #(
        .CLIENT_CNT (NC),
        .WAIT_STATES(WS),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_rdata(mem_rdata),
        .addr     (addr),
        .data_out (data_out),
        .we       (we),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT pins, with a bench-side preload port.
    logic [DW-1:0] mem [256];
    logic          tb_wr = 1'b0;
    logic [AW-1:0] tb_wa = '0;
    logic [DW-1:0] tb_wd = '0;
    assign mem_rdata = mem[addr];
    always @(posedge clk) begin
        if (tb_wr) mem[tb_wa] <= tb_wd;
        else if (we) mem[addr] <= data_out;
    end

    // Reference model state.
    logic [DW-1:0] mdl_mem [256];
    logic [DW-1:0] mdl_rdata;
    int            mdl_ptr;
    job_t          cq [NC][$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_job(input int c, input job_t j);
        bus.requests[c]            = 1'b1;
        bus.addrs[c*AW +: AW]      = j.a;
        bus.data_outs[c*DW +: DW]  = j.d;
        bus.wes[c]                 = j.w;
        bus.locks[c]               = j.l;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_wr = 1'b1; tb_wa = a; tb_wd = d;
        mdl_mem[a] = d;
        tick();
        tb_wr = 1'b0;
    endtask

    // Serve all queued jobs; order is round robin from the model pointer,
    // a locked chain being served back to back.
    task automatic run_round();
        int exp_c[$];
        bit raise_next [NC];
        int edges      = 0;
        int we_cnt     = 0;
        int hold_owner = -1;
        bit first      = 1'b1;
        bit timed_out  = 1'b0;
        for (int k = 1; k <= NC; k++) begin
            int c;
            c = (mdl_ptr + k) % NC;
            for (int j = 0; j < cq[c].size(); j++) exp_c.push_back(c);
        end
        if (exp_c.size() == 0) return;
        for (int c = 0; c < NC; c++) begin
            raise_next[c] = 1'b0;
            if (cq[c].size() > 0) drive_job(c, cq[c][0]);
        end
        while (!timed_out && (exp_c.size() > 0 || bus.requests != '0)) begin
            tick();
            edges++;
            if (we) we_cnt++;
            if (hold_owner >= 0) check("hold_grant_id", grant_id, hold_owner);
            for (int c = 0; c < NC; c++) begin
                if (bus.requests[c] && bus.readies[c] && cq[c].size() > 0) begin
                    job_t j;
                    j = cq[c].pop_front();
                    check("grant_order", c, exp_c.size() > 0 ? exp_c[0] : -1);
                    check("readies_vec", bus.readies, 64'(1) << c);
                    check("grant_id", grant_id, c);
                    check("addr", addr, j.a);
                    check("we_low_at_ready", we, 0);
                    if (first) check("ready_latency", edges, WS + 2);
                    first = 1'b0;
                    if (j.w) begin
                        check("data_out", data_out, j.d);
                        check("we_cycles", we_cnt, WS + 1);
                        check("rdata_kept", bus.rdata, mdl_rdata);
                        mdl_mem[j.a] = j.d;
                    end else begin
                        check("we_cycles_read", we_cnt, 0);
                        mdl_rdata = mdl_mem[j.a];
                        check("rdata", bus.rdata, mdl_rdata);
                    end
                    we_cnt  = 0;
                    mdl_ptr = c;
                    if (exp_c.size() > 0) void'(exp_c.pop_front());
                    bus.requests[c] = 1'b0;
                    if (cq[c].size() > 0) begin
                        raise_next[c] = 1'b1;
                        hold_owner    = c;
                    end else begin
                        hold_owner = -1;
                    end
                end else if (raise_next[c]) begin
                    raise_next[c] = 1'b0;
                    drive_job(c, cq[c][0]);
                end
            end
            if (edges > 200) begin
                check("round_timeout", exp_c.size(), 0);
                timed_out    = 1'b1;
                bus.requests = '0;
                for (int c = 0; c < NC; c++) cq[c].delete();
            end
        end
        tick();
        check("round_end_idle", busy, 0);
        check("round_end_readies", bus.readies, 0);
    endtask

    task automatic early_drop();
        job_t j;
        int   n  = 0;
        int   hi = 0;
        j = '{a: 8'h44, d: 8'h00, w: 1'b0, l: 1'b0};
        drive_job(0, j);
        tick();
        bus.requests[0] = 1'b0;
        while (!bus.readies[0] && n < 20) begin
            tick();
            n++;
        end
        check("early_ready_seen", bus.readies[0], 1);
        mdl_rdata = mdl_mem[j.a];
        check("early_rdata", bus.rdata, mdl_rdata);
        while (bus.readies[0] && hi < 20) begin
            hi++;
            tick();
        end
        check("early_ready_width", hi, 1);
        check("early_idle", busy, 0);
        mdl_ptr = 0;
    endtask

    task automatic reset_mid_write();
        job_t j;
        j = '{a: 8'h55, d: 8'hA5, w: 1'b1, l: 1'b0};
        drive_job(1, j);
        tick();
        check("pre_reset_we", we, 1);
        rst          = 1'b1;
        bus.requests = '0;
        tick();
        check("rst_we", we, 0);
        check("rst_readies", bus.readies, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        // The write strobe was high for one edge before reset took effect.
        mdl_mem[j.a] = j.d;
        mdl_ptr      = NC - 1;
        mdl_rdata    = '0;
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.a = AW'($urandom);
        j.d = DW'($urandom);
        j.w = $urandom_range(1);
        j.l = 1'b0;
        return j;
    endfunction

    initial begin
        rst           = 1'b1;
        bus.requests  = '0;
        bus.addrs     = '0;
        bus.wes       = '0;
        bus.data_outs = '0;
        bus.locks     = '0;
        mdl_ptr       = NC - 1;
        mdl_rdata     = '0;

        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            tb_wr = 1'b1;
            tb_wa = AW'(i);
            tb_wd = DW'($urandom);
            mdl_mem[i] = tb_wd;
            @(negedge clk);
        end
        tb_wr = 1'b0;

        check("reset_readies", bus.readies, 0);
        check("reset_rdata", bus.rdata, 0);
        check("reset_addr", addr, 0);
        check("reset_data_out", data_out, 0);
        check("reset_we", we, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single read by client 0.
        preload(8'h10, 8'h5A);
        cq[0].push_back('{a: 8'h10, d: 8'h00, w: 1'b0, l: 1'b0});
        run_round();
        check("read_5a", bus.rdata, 8'h5A);

        // Single write by client 1.
        cq[1].push_back('{a: 8'h20, d: 8'hC3, w: 1'b1, l: 1'b0});
        run_round();

        // Fairness: both clients contend twice.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NC; c++) cq[c].push_back(rand_job());
            run_round();
        end

        early_drop();

        // Locked read-modify-write by client 1 while client 0 waits.
        cq[1].push_back('{a: 8'h30, d: 8'h00, w: 1'b0, l: 1'b1});
        cq[1].push_back('{a: 8'h31, d: 8'h77, w: 1'b1, l: 1'b0});
        cq[0].push_back('{a: 8'h40, d: 8'h00, w: 1'b0, l: 1'b0});
        run_round();

        reset_mid_write();
        for (int c = 0; c < NC; c++) cq[c].push_back(rand_job());
        run_round();

        // Random rounds mixing single accesses and locked chains.
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(3) != 0) begin
                    if ($urandom_range(2) == 0) begin
                        job_t rd;
                        job_t wr;
                        rd   = rand_job();
                        rd.w = 1'b0;
                        rd.l = 1'b1;
                        wr   = rand_job();
                        wr.a = rd.a;
                        wr.w = 1'b1;
                        cq[c].push_back(rd);
                        cq[c].push_back(wr);
                    end else begin
                        cq[c].push_back(rand_job());
                    end
                end
            end
            run_round();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
